banked_memory_ctrl: RTL and testbench

// - Byte-lane-banked data memory with valid/ready request and response channels; serves the core's load/store unit.
// - Stripes NUM_BANKS lanes across memory_bank instances, so any lane-aligned address (misaligned words included) is served in one access.
// - Read data comes from synchronous banks. Response data is held under back-pressure, giving one access per cycle.

---
 rtl/banked_mem_pkg.sv | 26 ++
 rtl/lane_rotator.sv | 26 ++
 rtl/memory_bank.sv | 29 ++
 rtl/banked_memory_ctrl.sv | 177 +++++++++++++++++
 tb/tb_banked_memory_ctrl.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/banked_mem_pkg.sv
// Shared types and helpers for the byte-lane-banked data memory controller.
package banked_mem_pkg;

  localparam int DEF_NUM_BANKS  = 4;
  localparam int DEF_BANK_WIDTH = 8;
  localparam int DEF_BANK_DEPTH = 8192;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    STALL  = 2'd2
  } mem_state_e;

  // Source lane feeding output lane 'lane' when rotating by 'shift' lanes.
  // Left moves data towards higher lanes (request -> bank), right undoes it.
  function automatic int unsigned rotate_lane_idx(input int unsigned lane,
                                                  input int unsigned shift,
                                                  input int unsigned lanes,
                                                  input bit          left);
    int unsigned s;
    s = shift % lanes;
    if (left) return (lane + lanes - s) % lanes;
    else      return (lane + s) % lanes;
  endfunction

endpackage

// File: rtl/lane_rotator.sv
// Barrel rotate of a word by whole lanes, direction fixed at elaboration.
module lane_rotator
  import banked_mem_pkg::*;
#(
  parameter int NUM_LANES   = 4,
  parameter int LANE_WIDTH  = 8,
  parameter bit ROTATE_LEFT = 1'b1,
  localparam int W       = NUM_LANES * LANE_WIDTH,
  localparam int SHIFT_W = $clog2(NUM_LANES)
) (
  input  logic [W-1:0]       data_i,
  input  logic [SHIFT_W-1:0] shift_i,
  output logic [W-1:0]       data_o
);

  always_comb begin
    // NOTE: a default assignment first keeps combinational blocks from
    // inferring latches if a later path forgets to assign.
    data_o = '0;
    for (int unsigned l = 0; l < NUM_LANES; l++) begin
      data_o[l*LANE_WIDTH +: LANE_WIDTH] =
        data_i[rotate_lane_idx(l, 32'(shift_i), NUM_LANES, ROTATE_LEFT)*LANE_WIDTH +: LANE_WIDTH];
    end
  end

endmodule

// File: rtl/memory_bank.sv
// Single-port synchronous-read RAM bank; read and write only when enabled.
module memory_bank #(
  parameter int DATA_WIDTH = 8,
  parameter int DATA_DEPTH = 8192,
  localparam int ADDR_W = $clog2(DATA_DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  en_i,
  input  logic                  we_i,
  input  logic [ADDR_W-1:0]     addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DATA_DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  // NOTE: the array has no reset so it maps onto RAM macros; sequential
  // state is always updated with non-blocking assignments.
  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) mem_q[addr_i] <= wdata_i;
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/banked_memory_ctrl.sv
// Lane-striped data memory with valid/ready request/response channels.
// Optional bounds checking is enabled by defining MEM_BOUNDS_CHECK_EN.
module banked_memory_ctrl
  import banked_mem_pkg::*;
#(
  parameter int NUM_BANKS  = DEF_NUM_BANKS,
  parameter int BANK_WIDTH = DEF_BANK_WIDTH,
  parameter int BANK_DEPTH = DEF_BANK_DEPTH,
  localparam int DATA_W = NUM_BANKS * BANK_WIDTH,
  localparam int ADDR_W = $clog2(NUM_BANKS * BANK_DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [NUM_BANKS-1:0] req_wmask_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  output logic              resp_valid_o,
  input  logic              resp_ready_i,
  output logic [DATA_W-1:0] resp_rdata_o,
  output logic              resp_err_o
);

  localparam int LANE_W = $clog2(NUM_BANKS);
  localparam int ROW_W  = $clog2(BANK_DEPTH);

  mem_state_e           state_q;
  logic [LANE_W-1:0]    base_q;
  logic                 blank_q;
  logic [DATA_W-1:0]    hold_q;

  logic                 accept;
  logic                 bank_en;
  logic                 is_write;
  logic                 fault;
  logic [LANE_W-1:0]    base;
  logic [ROW_W-1:0]     row;
  logic [ROW_W-1:0]     row_inc;
  logic [DATA_W-1:0]    bank_wdata;
  logic [NUM_BANKS-1:0] bank_wmask;
  logic [DATA_W-1:0]    bank_rdata;
  logic [DATA_W-1:0]    rot_rdata;
  logic [DATA_W-1:0]    active_rdata;

  assign req_ready_o = (state_q == IDLE) || resp_ready_i;
  assign accept      = req_valid_i && req_ready_o;
  assign bank_en     = accept && !rst_i;
  assign is_write    = |req_wmask_i;

  assign base    = req_addr_i[LANE_W-1:0];
  assign row     = req_addr_i[ADDR_W-1:LANE_W];
  assign row_inc = row + ROW_W'(1);

`ifdef MEM_BOUNDS_CHECK_EN
  logic              err_q;
  logic [LANE_W-1:0] last_lane;
  logic [ADDR_W:0]   span;

  // Highest lane touched: the top enabled lane for writes, all lanes for reads.
  always_comb begin
    last_lane = '0;
    for (int unsigned k = 0; k < NUM_BANKS; k++) begin
      if (req_wmask_i[k]) last_lane = LANE_W'(k);
    end
    if (!is_write) last_lane = LANE_W'(NUM_BANKS - 1);
  end

  assign span       = {1'b0, req_addr_i} + {{(ADDR_W + 1 - LANE_W){1'b0}}, last_lane};
  assign fault      = span[ADDR_W];
  assign resp_err_o = resp_valid_o && err_q;
`else
  assign fault      = 1'b0;
  assign resp_err_o = 1'b0;
`endif

  lane_rotator #(
    .NUM_LANES  (NUM_BANKS),
    .LANE_WIDTH (BANK_WIDTH),
    .ROTATE_LEFT(1'b1)
  ) u_wdata_rot (
    .data_i (req_wdata_i),
    .shift_i(base),
    .data_o (bank_wdata)
  );

  lane_rotator #(
    .NUM_LANES  (NUM_BANKS),
    .LANE_WIDTH (1),
    .ROTATE_LEFT(1'b1)
  ) u_wmask_rot (
    .data_i (req_wmask_i),
    .shift_i(base),
    .data_o (bank_wmask)
  );

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic [ROW_W-1:0] bank_row;

    // Banks below the base lane hold the tail of the access on the next row.
    assign bank_row = (LANE_W'(b) < base) ? row_inc : row;

    memory_bank #(
      .DATA_WIDTH(BANK_WIDTH),
      .DATA_DEPTH(BANK_DEPTH)
    ) u_bank (
      .clk_i  (clk_i),
      .en_i   (bank_en),
      .we_i   (bank_en && bank_wmask[b] && !fault),
      .addr_i (bank_row),
      .wdata_i(bank_wdata[b*BANK_WIDTH +: BANK_WIDTH]),
      .rdata_o(bank_rdata[b*BANK_WIDTH +: BANK_WIDTH])
    );
  end

  // Rotation uses the base captured at accept, not the live request address.
  lane_rotator #(
    .NUM_LANES  (NUM_BANKS),
    .LANE_WIDTH (BANK_WIDTH),
    .ROTATE_LEFT(1'b0)
  ) u_rdata_rot (
    .data_i (bank_rdata),
    .shift_i(base_q),
    .data_o (rot_rdata)
  );

  assign active_rdata = blank_q ? '0 : rot_rdata;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      base_q  <= '0;
      blank_q <= 1'b0;
      hold_q  <= '0;
`ifdef MEM_BOUNDS_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      if (accept) begin
        base_q  <= base;
        blank_q <= is_write || fault;
`ifdef MEM_BOUNDS_CHECK_EN
        err_q   <= fault;
`endif
      end
      case (state_q)
        IDLE: begin
          if (accept) state_q <= ACTIVE;
        end
        ACTIVE: begin
          if (resp_ready_i) begin
            state_q <= accept ? ACTIVE : IDLE;
          end else begin
            hold_q  <= active_rdata;
            state_q <= STALL;
          end
        end
        STALL: begin
          if (resp_ready_i) state_q <= accept ? ACTIVE : IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign resp_valid_o = (state_q != IDLE);

  always_comb begin
    resp_rdata_o = '0;
    case (state_q)
      ACTIVE:  resp_rdata_o = active_rdata;
      STALL:   resp_rdata_o = hold_q;
      default: resp_rdata_o = '0;
    endcase
  end

endmodule

// File: tb/tb_banked_memory_ctrl.sv
// Directed, table-driven bench for banked_memory_ctrl (4 x 8-bit lanes, 8192 rows).
module tb_banked_memory_ctrl;

  localparam int ADDR_W = 15;
`ifdef MEM_BOUNDS_CHECK_EN
  localparam bit BC = 1'b1;
`else
  localparam bit BC = 1'b0;
`endif

  typedef struct {
    string       name;
    logic [14:0] addr;
    logic [3:0]  wmask;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [3:0]        req_wmask;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [31:0]       resp_rdata;
  logic              resp_err;

  int n_checks = 0;
  int n_errors = 0;

  banked_memory_ctrl dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_addr_i  (req_addr),
    .req_wmask_i (req_wmask),
    .req_wdata_i (req_wdata),
    .resp_valid_o(resp_valid),
    .resp_ready_i(resp_ready),
    .resp_rdata_o(resp_rdata),
    .resp_err_o  (resp_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string n, input logic [14:0] a, input logic [3:0] m,
                              input logic [31:0] d, input logic [31:0] r, input logic e);
    vec_t v;
    v.name = n; v.addr = a; v.wmask = m; v.wdata = d; v.exp_rdata = r; v.exp_err = e;
    return v;
  endfunction

  // One isolated access: drive at a falling edge, accept on the next rising
  // edge, then check the response one cycle after the accept.
  task automatic run_vec(input vec_t v);
    @(negedge clk);
    req_valid = 1'b1; req_addr = v.addr; req_wmask = v.wmask; req_wdata = v.wdata;
    resp_ready = 1'b1;
    #1;
    check({v.name, "/pre_valid"}, 32'(resp_valid), 32'd0);
    check({v.name, "/ready"}, 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    check({v.name, "/valid"}, 32'(resp_valid), 32'd1);
    check({v.name, "/rdata"}, resp_rdata, v.exp_rdata);
    check({v.name, "/err"}, 32'(resp_err), 32'(v.exp_err));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t pre[$];
    vec_t post[$];

    // Zero the low region read by later vectors, then the aligned case.
    for (int i = 0; i < 8; i++) pre.push_back(mk("clear", 15'(i * 4), 4'hF, 32'h0, 32'h0, 1'b0));
    pre.push_back(mk("aligned_wr", 15'h0000, 4'hF, 32'hDEADBEEF, 32'h0, 1'b0));
    pre.push_back(mk("aligned_rd", 15'h0000, 4'h0, 32'h0, 32'hDEADBEEF, 1'b0));

    post.push_back(mk("mis_wr", 15'h0003, 4'hF, 32'h11223344, 32'h0, 1'b0));
    post.push_back(mk("mis_rd3", 15'h0003, 4'h0, 32'h0, 32'h11223344, 1'b0));
    post.push_back(mk("mis_rd5", 15'h0005, 4'h0, 32'h0, 32'h00001122, 1'b0));
    post.push_back(mk("part_wr", 15'h0010, 4'b0101, 32'hAABBCCDD, 32'h0, 1'b0));
    post.push_back(mk("part_rd", 15'h0010, 4'h0, 32'h0, 32'h00BB00DD, 1'b0));
    post.push_back(mk("top_clr", 15'h7FFC, 4'hF, 32'h0, 32'h0, 1'b0));
    post.push_back(mk("top_part_wr", 15'h7FFE, 4'b0011, 32'h0000BEEF, 32'h0, 1'b0));
    post.push_back(mk("top_rd", 15'h7FFC, 4'h0, 32'h0, 32'hBEEF0000, 1'b0));
    post.push_back(mk("low_clr", 15'h0000, 4'hF, 32'h0, 32'h0, 1'b0));
    post.push_back(mk("wrap_wr", 15'h7FFE, 4'hF, 32'hCAFEF00D, 32'h0, BC));
    post.push_back(mk("wrap_rd0", 15'h0000, 4'h0, 32'h0, BC ? 32'h0 : 32'h0000CAFE, 1'b0));
    post.push_back(mk("wrap_rd_top", 15'h7FFE, 4'h0, 32'h0, BC ? 32'h0 : 32'hCAFEF00D, BC));
    post.push_back(mk("wrap_rd_fc", 15'h7FFC, 4'h0, 32'h0, BC ? 32'hBEEF0000 : 32'hF00D0000, 1'b0));

    rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_wmask = '0; req_wdata = '0; resp_ready = 1'b1;
    #1;
    check("rst/valid", 32'(resp_valid), 32'd0);
    check("rst/ready", 32'(req_ready), 32'd1);
    check("rst/rdata", resp_rdata, 32'h0);
    check("rst/err", 32'(resp_err), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    foreach (pre[i]) run_vec(pre[i]);

    // Back-pressure: response held for three cycles with a new request waiting.
    @(negedge clk);
    req_valid = 1'b1; req_addr = 15'h0000; req_wmask = 4'h0; resp_ready = 1'b1;
    @(negedge clk);
    req_addr = 15'h0001; resp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      check("bp/ready", 32'(req_ready), 32'd0);
      check("bp/valid", 32'(resp_valid), 32'd1);
      check("bp/rdata", resp_rdata, 32'hDEADBEEF);
    end
    @(negedge clk);
    resp_ready = 1'b1;
    #1;
    check("bp_rel/ready", 32'(req_ready), 32'd1);
    check("bp_rel/rdata", resp_rdata, 32'hDEADBEEF);
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    check("bp_next/valid", 32'(resp_valid), 32'd1);
    check("bp_next/rdata", resp_rdata, 32'h00DEADBE);
    @(negedge clk);
    #1;
    check("bp_done/valid", 32'(resp_valid), 32'd0);

    // Reset while a response is stalled.
    @(negedge clk);
    req_valid = 1'b1; req_addr = 15'h0000; req_wmask = 4'h0; resp_ready = 1'b1;
    @(negedge clk);
    req_valid = 1'b0; resp_ready = 1'b0;
    @(negedge clk);
    #1;
    check("stall/valid", 32'(resp_valid), 32'd1);
    check("stall/rdata", resp_rdata, 32'hDEADBEEF);
    rst = 1'b1;
    #1;
    check("stall_rst/valid", 32'(resp_valid), 32'd0);
    check("stall_rst/rdata", resp_rdata, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst/ready", 32'(req_ready), 32'd1);
    check("post_rst/valid", 32'(resp_valid), 32'd0);
    run_vec(mk("post_rst_rd", 15'h0000, 4'h0, 32'h0, 32'hDEADBEEF, 1'b0));

    foreach (post[i]) run_vec(post[i]);

    // Back-to-back write then read of the same address.
    @(negedge clk);
    req_valid = 1'b1; req_addr = 15'h0020; req_wmask = 4'hF; req_wdata = 32'h01020304;
    resp_ready = 1'b1;
    @(negedge clk);
    req_wmask = 4'h0; req_wdata = 32'h0;
    #1;
    check("raw/wr_valid", 32'(resp_valid), 32'd1);
    check("raw/wr_rdata", resp_rdata, 32'h0);
    check("raw/ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    check("raw/rd_valid", 32'(resp_valid), 32'd1);
    check("raw/rd_rdata", resp_rdata, 32'h01020304);
    @(negedge clk);
    #1;
    check("raw/idle", 32'(resp_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
